lathe_panel_conditioner: RTL
============================

Name: lathe_panel_conditioner

Overview:
- Upstream input stage for the lathe PLC controller (tt_um_plc_prg core).
- Takes raw operator-panel contacts: START, STOP and E-STOP buttons plus the AUTO/MAN selector.
- Synchronises and debounces them, decodes the mode with MAN priority, and latches run/estop state.
- Delivers clean, glitch-free start/auto/man levels and a run_enable qualifier to the controller.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised samples required before a debounced output changes. Silicon builds use 50000; the value must be >= 2.
- CNT_W, 16: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start_raw  input  1  START pushbutton, active-high, asynchronous, bouncy
- stop_raw  input  1  STOP pushbutton, active-high, asynchronous, bouncy
- auto_raw  input  1  AUTO selector contact, active-high
- man_raw  input  1  MAN selector contact, active-high
- estop_n_raw  input  1  E-STOP loop, active-low (0 = emergency)
- start_level  output  1  debounced START level, gated by run state (see Behaviour)
- start_pulse  output  1  one-cycle pulse on debounced START rising edge
- auto_sel  output  1  AUTO mode selected (decoded)
- man_sel  output  1  MAN mode selected (decoded)
- mode_fault  output  1  both selector contacts closed
- estop_latched  output  1  emergency latched
- run_enable  output  1  high only in RUN state

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst_n is asynchronous and active-low.
  - All flops are cleared asynchronously on rst_n low.
- Reset values:
  - All outputs are 0, except estop_latched = 1.
  - FSM resets to ESTOP.
  - Synchroniser and debounced stable registers reset to the inactive level: 0 for active-high inputs, 1 for estop_n.
- Synchronisation:
  - Each raw input passes through a 2-flop synchroniser.
  - No logic is permitted between the two flops.
- Debounce, per channel:
  - The counter clears whenever the synchronised value equals the stable value.
  - Otherwise the counter increments.
  - When count reaches DEBOUNCE_CYCLES-1 while still disagreeing, stable takes the synced value and the counter clears.
  - Latency from a clean raw transition to stable is 2 + DEBOUNCE_CYCLES clk edges.
  - Pulses shorter than DEBOUNCE_CYCLES cycles produce no change.
- Edge detect:
  - start_pulse = stable_start AND NOT previous stable_start, registered.
  - Exactly 1 cycle wide, asserted the cycle after stable_start rises.
- Mode decode (registered):
  - man_sel = db_man.
  - auto_sel = db_auto AND NOT db_man.
  - mode_fault = db_auto AND db_man.
- FSM states:
  - ESTOP: estop_latched = 1, run_enable = 0.
  - IDLE: run_enable = 0.
  - RUN: run_enable = 1.
- FSM transitions, in priority order:
  1. Any state: db_estop_n = 0 -> ESTOP. This is the highest priority, the same cycle as the debounced edge.
  2. ESTOP -> IDLE when db_estop_n = 1 AND db_stop = 1. Stop acts as acknowledge; release alone does not clear.
  3. IDLE -> RUN on start_pulse when (auto_sel OR man_sel) AND db_stop = 0.
  4. RUN -> IDLE on db_stop = 1, on neither mode selected, or on any change of auto_sel/man_sel relative to the value captured at RUN entry.
- start_level:
  - Equals stable_start when the FSM is in RUN or IDLE; forced to 0 in ESTOP.
  - MAN-mode jog remains possible from IDLE.
- Simultaneous events:
  - start_pulse and db_stop in the same cycle resolve to IDLE (stop wins).
  - estop overrides everything.
  - mode_fault does not block RUN (MAN priority applies), but is reported.
- Reset mid-operation: the block returns to the reset values immediately and asynchronously. The debounce counters restart.

Test Plan:
- DEBOUNCE_CYCLES=4. Reset with estop_n_raw=1 and stop_raw=0; pulse stop_raw for 10 cycles -> estop_latched 1->0 at edge 2+4 after stop_raw rises. FSM goes to IDLE, run_enable=0.
- From IDLE with auto_raw=1: start_raw high for 10 cycles -> auto_sel=1; start_pulse exactly 1 cycle at edge 7 after start_raw rises; run_enable=1 on the next cycle.
- Bounce: toggle start_raw high 3 cycles, low 2, high 3, then low -> no change on start_level, start_pulse or run_enable.
- Both auto_raw=1 and man_raw=1 -> man_sel=1, auto_sel=0, mode_fault=1. Drop man_raw while in RUN -> RUN->IDLE after debounce, run_enable=0.
- In RUN: estop_n_raw to 0 for 10 cycles -> estop_latched=1, run_enable=0, start_level=0 at edge 6. Releasing estop alone leaves ESTOP held; holding stop then -> IDLE.
- Assert rst_n=0 mid-RUN, asynchronously between clock edges -> run_enable=0 and estop_latched=1 immediately, before the next edge.

Source files
------------

// File: rtl/lathe_panel_conditioner.sv
// Operator-panel front end for the lathe PLC core.
// Raw START/STOP/AUTO/MAN/E-STOP contacts are synchronised and debounced per
// channel, the selector is decoded with MAN priority, and a small ESTOP/IDLE/RUN
// FSM produces the run qualifier. Every output comes straight from a flop.

module lathe_panel_debounce #(
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter int   CNT_W           = 16,
    parameter logic RST_VAL         = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable_q_o,
    output logic stable_d_o
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta_q;
    logic             sync_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Two-flop synchroniser, flop straight into flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_q <= RST_VAL;
            sync_q      <= RST_VAL;
        end else begin
            sync_meta_q <= raw;
            sync_q      <= sync_meta_q;
        end
    end

    // Count consecutive samples that disagree with the stable level; take the
    // new level on the DEBOUNCE_CYCLES-th one. Any agreeing sample restarts it.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= RST_VAL;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_q_o = stable_q;
    assign stable_d_o = stable_d;
endmodule

module lathe_panel_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_raw,
    input  logic stop_raw,
    input  logic auto_raw,
    input  logic man_raw,
    input  logic estop_n_raw,
    output logic start_level,
    output logic start_pulse,
    output logic auto_sel,
    output logic man_sel,
    output logic mode_fault,
    output logic estop_latched,
    output logic run_enable
);
    localparam int NUM_CH   = 5;
    localparam int CH_START = 0;
    localparam int CH_STOP  = 1;
    localparam int CH_AUTO  = 2;
    localparam int CH_MAN   = 3;
    localparam int CH_ESTOP = 4;
    // Inactive level per channel: E-STOP loop is active-low, the rest active-high.
    localparam logic [NUM_CH-1:0] CH_RST = 5'b10000;

    typedef enum logic [1:0] {
        ST_ESTOP = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    logic [NUM_CH-1:0] raw_vec;
    logic [NUM_CH-1:0] db_q;
    logic [NUM_CH-1:0] db_d;

    assign raw_vec = {estop_n_raw, man_raw, auto_raw, stop_raw, start_raw};

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_chan
            lathe_panel_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W),
                .RST_VAL         (CH_RST[g])
            ) u_db (
                .clk        (clk),
                .rst_n      (rst_n),
                .raw        (raw_vec[g]),
                .stable_q_o (db_q[g]),
                .stable_d_o (db_d[g])
            );
        end
    endgenerate

    // STOP and E-STOP are acted on in the same cycle their debounced level
    // changes, so the FSM reads their next-state value; the registered copies
    // of those two and the next-state copies of AUTO/MAN are not needed.
    logic unused_db;
    assign unused_db = ^{db_q[CH_ESTOP], db_q[CH_STOP], db_d[CH_MAN], db_d[CH_AUTO]};

    logic   estop_n_d, stop_d;
    assign estop_n_d = db_d[CH_ESTOP];
    assign stop_d    = db_d[CH_STOP];

    state_t state_q, state_d;
    logic   cap_auto_q, cap_auto_d;
    logic   cap_man_q, cap_man_d;
    logic   prev_start_q, prev_start_d;
    logic   start_pulse_q, start_pulse_d;
    logic   auto_sel_q, auto_sel_d;
    logic   man_sel_q, man_sel_d;
    logic   mode_fault_q, mode_fault_d;
    logic   start_level_q, start_level_d;
    logic   estop_latched_q, estop_latched_d;
    logic   run_enable_q, run_enable_d;

    // Next state: E-STOP first, STOP acknowledges ESTOP, START enters RUN only
    // with a mode selected and STOP released; RUN drops on STOP or mode change.
    always_comb begin
        state_d    = state_q;
        cap_auto_d = cap_auto_q;
        cap_man_d  = cap_man_q;
        if (!estop_n_d) begin
            state_d = ST_ESTOP;
        end else begin
            case (state_q)
                ST_ESTOP: begin
                    if (stop_d) state_d = ST_IDLE;
                end
                ST_IDLE: begin
                    if (start_pulse_q && (auto_sel_q || man_sel_q) && !stop_d) begin
                        state_d    = ST_RUN;
                        cap_auto_d = auto_sel_q;
                        cap_man_d  = man_sel_q;
                    end
                end
                ST_RUN: begin
                    if (stop_d || !(auto_sel_q || man_sel_q) ||
                        (auto_sel_q != cap_auto_q) || (man_sel_q != cap_man_q)) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_ESTOP;
            endcase
        end
    end

    // Registered outputs: edge detect, MAN-priority decode and state flags.
    always_comb begin
        prev_start_d    = db_q[CH_START];
        start_pulse_d   = db_q[CH_START] & ~prev_start_q;
        man_sel_d       = db_q[CH_MAN];
        auto_sel_d      = db_q[CH_AUTO] & ~db_q[CH_MAN];
        mode_fault_d    = db_q[CH_AUTO] & db_q[CH_MAN];
        start_level_d   = (state_d != ST_ESTOP) & db_d[CH_START];
        estop_latched_d = (state_d == ST_ESTOP);
        run_enable_d    = (state_d == ST_RUN);
    end

    // State and output registers; reset lands in ESTOP with the latch set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_ESTOP;
            cap_auto_q      <= 1'b0;
            cap_man_q       <= 1'b0;
            prev_start_q    <= 1'b0;
            start_pulse_q   <= 1'b0;
            auto_sel_q      <= 1'b0;
            man_sel_q       <= 1'b0;
            mode_fault_q    <= 1'b0;
            start_level_q   <= 1'b0;
            estop_latched_q <= 1'b1;
            run_enable_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cap_auto_q      <= cap_auto_d;
            cap_man_q       <= cap_man_d;
            prev_start_q    <= prev_start_d;
            start_pulse_q   <= start_pulse_d;
            auto_sel_q      <= auto_sel_d;
            man_sel_q       <= man_sel_d;
            mode_fault_q    <= mode_fault_d;
            start_level_q   <= start_level_d;
            estop_latched_q <= estop_latched_d;
            run_enable_q    <= run_enable_d;
        end
    end

    assign start_level   = start_level_q;
    assign start_pulse   = start_pulse_q;
    assign auto_sel      = auto_sel_q;
    assign man_sel       = man_sel_q;
    assign mode_fault    = mode_fault_q;
    assign estop_latched = estop_latched_q;
    assign run_enable    = run_enable_q;
endmodule
